// File: rtl/vga_line_fetch.sv
// Ping-pong line prefetcher feeding the VGA driver. Line n+1 is read from the
// framebuffer while line n is replayed. Optional colour-bar generator: VGA_LINE_FETCH_TESTPAT_EN.
module vga_line_fetch #(
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480,
  parameter int ADDR_W    = 20,
  parameter int MAX_OUTST = 8
) (
  input  logic              clk27,
  input  logic              rst27,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              vga_vs,
  input  logic              request,
  input  logic [9:0]        current_x,
`ifdef VGA_LINE_FETCH_TESTPAT_EN
  input  logic              testpat,
`endif
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [23:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic              busy,
  output logic              underrun
);

  localparam int CNT_W  = $clog2(H_ACT + 1);
  localparam int IDX_W  = $clog2(H_ACT);
  localparam int LINE_W = $clog2(V_ACT + 1);
  localparam logic [CNT_W-1:0]  H_CNT     = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0]  OUTST_CNT = CNT_W'(MAX_OUTST);
  localparam logic [LINE_W-1:0] V_CNT     = LINE_W'(V_ACT);
  localparam logic [10:0]       H_X       = 11'(H_ACT);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    issued_reg, returned_reg;
  logic [ADDR_W-1:0]   addr_reg, fb_base_q_reg;
  logic [LINE_W-1:0]   fetch_line_reg;
  logic                wsel_reg, fill_sel_reg, disp_sel_reg, disp_q_reg;
  logic                pend_frame_reg, pend_line_reg, auto_next_reg;
  logic                underrun_reg, vs_q_reg, req_q_reg;

  logic                frame_edge, line_end, can_start, fetch_en;
  logic                start_frame, start_auto, start_line, drop_line, start;
  logic [LINE_W-1:0]   line_now, start_no;
  logic                start_sel;
  logic [ADDR_W-1:0]   start_addr;
  logic                issue, ret;
  logic [IDX_W-1:0]    x_clamp;
  logic [23:0]         rd_data, pix;
  logic [23:0]         bank_rd [2];

  assign frame_edge = vs_q_reg & ~vga_vs;
  assign line_end   = req_q_reg & ~request;
  assign can_start  = fetch_en && (state_reg == IDLE || state_reg == DONE);

  // In DONE the line counter has not advanced yet, so look one line ahead.
  assign line_now    = (state_reg == DONE) ? fetch_line_reg + LINE_W'(1) : fetch_line_reg;
  assign start_frame = can_start & pend_frame_reg;
  assign start_auto  = can_start & ~pend_frame_reg & (state_reg == DONE) & auto_next_reg;
  assign start_line  = can_start & ~pend_frame_reg & ~start_auto & pend_line_reg & (line_now < V_CNT);
  assign drop_line   = can_start & ~pend_frame_reg & ~start_auto & pend_line_reg & ~(line_now < V_CNT);
  assign start       = start_frame | start_auto | start_line;
  assign start_no    = start_frame ? '0 : line_now;
  assign start_sel   = start_frame ? 1'b0 : (start_auto ? 1'b1 : fill_sel_reg);
  assign start_addr  = fb_base_q_reg + ADDR_W'(start_no) * ADDR_W'(H_ACT);

  assign mem_read = fetch_en && (state_reg == FETCH) && (issued_reg < H_CNT)
                    && ((issued_reg - returned_reg) < OUTST_CNT);
  assign mem_addr = addr_reg;
  assign issue    = mem_read & ~mem_waitrequest;
  assign ret      = mem_readdatavalid && (state_reg == FETCH) && (returned_reg != H_CNT);
  assign busy     = (state_reg == FETCH) || (state_reg == DONE);
  assign underrun = underrun_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (returned_reg == H_CNT) state_next = DONE;
      DONE:    state_next = start ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk27) begin
    if (rst27) begin
      state_reg      <= IDLE;
      issued_reg     <= '0;
      returned_reg   <= '0;
      addr_reg       <= '0;
      fb_base_q_reg  <= '0;
      fetch_line_reg <= '0;
      wsel_reg       <= 1'b0;
      fill_sel_reg   <= 1'b0;
      disp_sel_reg   <= 1'b0;
      disp_q_reg     <= 1'b0;
      pend_frame_reg <= 1'b0;
      pend_line_reg  <= 1'b0;
      auto_next_reg  <= 1'b0;
      underrun_reg   <= 1'b0;
      vs_q_reg       <= 1'b0;
      req_q_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      vs_q_reg   <= vga_vs;
      req_q_reg  <= request;
      disp_q_reg <= disp_sel_reg;
      if (issue) begin
        issued_reg <= issued_reg + CNT_W'(1);
        addr_reg   <= addr_reg + ADDR_W'(1);
      end
      if (ret) returned_reg <= returned_reg + CNT_W'(1);
      // A pending frame start restarts numbering, so the finished line is not counted.
      if (state_reg == DONE && !pend_frame_reg) fetch_line_reg <= fetch_line_reg + LINE_W'(1);
      if (start) begin
        issued_reg     <= '0;
        returned_reg   <= '0;
        addr_reg       <= start_addr;
        wsel_reg       <= start_sel;
        fetch_line_reg <= start_no;
      end
      if (start_frame) begin
        pend_frame_reg <= 1'b0;
        auto_next_reg  <= 1'b1;
      end
      if (start_auto) begin
        auto_next_reg <= 1'b0;
        fill_sel_reg  <= 1'b1;
      end
      if (start_line || drop_line) pend_line_reg <= 1'b0;
      if (line_end) begin
        disp_sel_reg <= ~disp_sel_reg;
        if (line_now < V_CNT) begin
          fill_sel_reg  <= disp_sel_reg;
          pend_line_reg <= 1'b1;
        end
        if (state_reg == FETCH) underrun_reg <= 1'b1;
      end
      if (frame_edge) begin
        fb_base_q_reg  <= fb_base;
        fetch_line_reg <= '0;
        disp_sel_reg   <= 1'b0;
        fill_sel_reg   <= 1'b0;
        underrun_reg   <= 1'b0;
        pend_frame_reg <= 1'b1;
        pend_line_reg  <= 1'b0;
        auto_next_reg  <= 1'b0;
      end
    end
  end

  assign x_clamp = ({1'b0, current_x} >= H_X) ? IDX_W'(H_ACT - 1) : IDX_W'(current_x);

  // Both banks are read every cycle; the registered display select picks one.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [23:0] mem [0:H_ACT-1];
      logic [23:0] rd_reg;
      always_ff @(posedge clk27) begin
        if (ret && wsel_reg == 1'(gi)) mem[returned_reg[IDX_W-1:0]] <= mem_readdata;
        rd_reg <= mem[x_clamp];
      end
      assign bank_rd[gi] = rd_reg;
    end
  endgenerate

  assign rd_data = bank_rd[disp_q_reg];

`ifdef VGA_LINE_FETCH_TESTPAT_EN
  logic             tp_q_reg;
  logic [23:0]      pat_reg;
  logic [IDX_W-1:0] bar_full;
  logic [2:0]       bar;

  always_comb begin
    bar_full = x_clamp / IDX_W'(H_ACT / 8);
    bar      = (bar_full > IDX_W'(7)) ? 3'd7 : bar_full[2:0];
  end

  // Bar order white..black maps to r=~bar[1], g=~bar[2], b=~bar[0].
  always_ff @(posedge clk27) begin
    if (rst27) begin
      tp_q_reg <= 1'b0;
      pat_reg  <= '0;
    end else begin
      tp_q_reg <= testpat;
      pat_reg  <= {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    end
  end

  assign pix      = tp_q_reg ? pat_reg : rd_data;
  assign fetch_en = ~testpat;
`else
  assign pix      = rd_data;
  assign fetch_en = 1'b1;
`endif

  assign {r, g, b} = req_q_reg ? pix : 24'd0;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Scoreboard bench for vga_line_fetch: a memory slave model checks read
// addresses and flow control, a pixel monitor checks the replayed lines.
module tb_vga_line_fetch;
  localparam int H_ACT  = 640;
  localparam int ADDR_W = 20;

  logic              clk27 = 1'b0;
  logic              rst27 = 1'b1;
  logic [ADDR_W-1:0] fb_base = '0;
  logic              vga_vs = 1'b1;
  logic              request = 1'b0;
  logic [9:0]        current_x = '0;
  logic [7:0]        r, g, b;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_waitrequest = 1'b0;
  logic [23:0]       mem_readdata = '0;
  logic              mem_readdatavalid = 1'b0;
  logic              busy, underrun;
`ifdef VGA_LINE_FETCH_TESTPAT_EN
  logic              testpat = 1'b0;
`endif

  vga_line_fetch dut (
    .clk27(clk27), .rst27(rst27), .fb_base(fb_base), .vga_vs(vga_vs),
    .request(request), .current_x(current_x),
`ifdef VGA_LINE_FETCH_TESTPAT_EN
    .testpat(testpat),
`endif
    .r(r), .g(g), .b(b), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .busy(busy), .underrun(underrun)
  );

  always #5 clk27 = ~clk27;

  int cyc = 0;
  always @(posedge clk27) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory slave model and read scoreboard
  int                lat = 1;
  bit                wr_mode = 1'b0;
  int                sq_due[$];
  logic [23:0]       sq_data[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int                acc_cnt = 0;
  int                ret_cnt = 0;
  bit                rst_seen = 1'b0;
  bit                stall_prev = 1'b0;
  logic [ADDR_W-1:0] stall_addr = '0;

  always @(posedge clk27) if (rst27) rst_seen = 1'b1;

  always @(negedge clk27) begin : slave
    if (rst_seen) begin
      sq_due.delete(); sq_data.delete(); exp_addr.delete();
      acc_cnt = 0; ret_cnt = 0; stall_prev = 1'b0; rst_seen = 1'b0;
    end
    if (sq_due.size() > 0 && sq_due[0] <= cyc) begin
      void'(sq_due.pop_front());
      mem_readdata      = sq_data.pop_front();
      mem_readdatavalid = 1'b1;
      ret_cnt++;
    end else begin
      mem_readdatavalid = 1'b0;
      mem_readdata      = '0;
    end
    mem_waitrequest = wr_mode && (cyc % 3 == 0);
    if (stall_prev) begin
      check("stall_read_held", 32'(mem_read), 32'd1);
      check("stall_addr_held", 32'(mem_addr), 32'(stall_addr));
    end
    stall_prev = mem_read && mem_waitrequest;
    stall_addr = mem_addr;
    if (mem_read && !mem_waitrequest) begin
      acc_cnt++;
      if (exp_addr.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_read: got addr %h expected no read", mem_addr);
      end else begin
        check("read_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
      end
      check("outstanding_le_8", 32'((acc_cnt - ret_cnt) <= 8), 32'd1);
      sq_due.push_back(cyc + lat);
      sq_data.push_back(24'(mem_addr));
    end
  end

  // Pixel scoreboard
  int          pq_due[$];
  logic [23:0] pq_val[$];

  always @(negedge clk27) begin : pix_mon
    while (pq_due.size() > 0 && pq_due[0] <= cyc) begin
      void'(pq_due.pop_front());
      check("pixel", 32'({r, g, b}), 32'(pq_val.pop_front()));
    end
  end

  task automatic tick();
    @(negedge clk27);
  endtask

  task automatic push_line(input int base, input int line);
    for (int i = 0; i < H_ACT; i++) exp_addr.push_back(ADDR_W'(base + line * H_ACT + i));
  endtask

  task automatic vs_pulse(input int base);
    fb_base = ADDR_W'(base);
    vga_vs  = 1'b0;
    tick(); tick();
    vga_vs  = 1'b1;
  endtask

  task automatic wait_ret(input int n, input int budget);
    int k = 0;
    while (ret_cnt < n && k < budget) begin tick(); k++; end
    check("wait_returns", 32'(ret_cnt >= n), 32'd1);
  endtask

  task automatic pix(input logic req, input int x, input logic [23:0] exp);
    request   = req;
    current_x = 10'(x);
    pq_due.push_back(cyc + 1);
    pq_val.push_back(exp);
    tick();
  endtask

  // Replay a full line whose word i was read from address base+i.
  task automatic show_line(input int base);
    for (int x = 0; x < H_ACT; x++) pix(1'b1, x, 24'((base + x) & 32'hFFFFF));
    pix(1'b1, 700, 24'((base + H_ACT - 1) & 32'hFFFFF));
    pix(1'b1, 1023, 24'((base + H_ACT - 1) & 32'hFFFFF));
    for (int k = 0; k < 4; k++) pix(1'b0, k * 3, 24'd0);
  endtask

  task automatic do_reset();
    rst27 = 1'b1;
    tick();
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rgb", 32'({r, g, b}), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst27 = 1'b0;
    tick(); tick();
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r0;
    int a0;
    repeat (3) tick();
    do_reset();

    // Reset in the middle of a fetch
    lat = 1; wr_mode = 1'b0;
    push_line(32'h10000, 0); push_line(32'h10000, 1);
    vs_pulse(32'h10000);
    wait_ret(100, 2000);
    do_reset();

    // Frame start: line 0 then line 1 fetched back to back
    push_line(32'h10000, 0); push_line(32'h10000, 1);
    vs_pulse(32'h10000);
    wait_ret(1280, 4000);
    repeat (4) tick();
    check("busy_after_fetch", 32'(busy), 32'd0);
    check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);

    // Display lines 0 and 1; each line end fetches two lines ahead
    push_line(32'h10000, 2);
    show_line(32'h10000);
    wait_ret(1920, 3000);
    repeat (4) tick();
    check("busy_line2", 32'(busy), 32'd0);
    check("no_underrun_0", 32'(underrun), 32'd0);
    push_line(32'h10000, 3);
    show_line(32'h10000 + H_ACT);
    wait_ret(2560, 3000);
    repeat (4) tick();
    check("no_underrun_1", 32'(underrun), 32'd0);

    // Stalling, long-latency slave with base near the top of the address space
    lat = 20; wr_mode = 1'b1;
    r0 = ret_cnt;
    push_line(32'hFFF00, 0); push_line(32'hFFF00, 1);
    vs_pulse(32'hFFF00);
    wait_ret(r0 + 1280, 20000);
    repeat (4) tick();
    check("busy_after_stall_fetch", 32'(busy), 32'd0);
    push_line(32'hFFF00, 2);
    show_line(32'hFFF00);
    wait_ret(r0 + 1920, 10000);
    repeat (30) tick();
    check("addr_queue_drained_2", 32'(exp_addr.size()), 32'd0);

    // Underrun: line end while the slow fetch is still running
    wr_mode = 1'b0; lat = 2000;
    push_line(0, 0); push_line(0, 1);
    vs_pulse(0);
    repeat (5) tick();
    request = 1'b1;
    for (int x = 0; x < 10; x++) begin current_x = 10'(x); tick(); end
    request = 1'b0;
    tick();
    check("underrun_set", 32'(underrun), 32'd1);
    check("busy_during_underrun", 32'(busy), 32'd1);
    repeat (200) tick();
    check("underrun_sticky", 32'(underrun), 32'd1);
    vga_vs = 1'b0;
    tick();
    check("underrun_cleared_by_vs", 32'(underrun), 32'd0);
    vga_vs = 1'b1;
    lat = 1;
    do_reset();

`ifdef VGA_LINE_FETCH_TESTPAT_EN
    // Colour bars; no memory traffic while the pattern is selected
    testpat = 1'b1;
    a0 = acc_cnt;
    vs_pulse(0);
    repeat (5) tick();
    pix(1'b1, 85, 24'hFFFF00);
    pix(1'b1, 639, 24'h000000);
    pix(1'b1, 0, 24'hFFFFFF);
    pix(1'b1, 300, 24'h00FF00);
    pix(1'b1, 500, 24'h0000FF);
    pix(1'b1, 420, 24'hFF0000);
    pix(1'b0, 85, 24'h000000);
    repeat (10) tick();
    check("testpat_mem_read", 32'(mem_read), 32'd0);
    check("testpat_no_reads", 32'(acc_cnt), 32'(a0));
    do_reset();
    testpat = 1'b0;
`else
    a0 = 0;
`endif

    repeat (3) tick();
    check("pixel_queue_drained", 32'(pq_due.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
